// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pad bus among NREQ requesters, with turnaround gaps and tenure timeout.
// Optional build macro UIO_ARB_PRIO0_EN gives requester 0 fixed priority at arbitration time.
module uio_bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int TURN     = 1,
  parameter int HOLD_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   dir,
  input  logic [NREQ-1:0]   done,
  input  logic [NREQ*8-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [7:0]        rdata,
  output logic              rvalid,
  output logic              busy,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TCW = $clog2(TURN + 1) + 1;
  localparam int HCW = $clog2(HOLD_MAX + 1) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TURN = 2'd1;
  localparam logic [1:0] S_OWN  = 2'd2;

  logic [1:0]      state_reg, state_next;
  logic [IW-1:0]   owner_reg, owner_next;
  logic            dir_reg, dir_next;
  logic [TCW-1:0]  turn_cnt_reg, turn_cnt_next;
  logic [HCW-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [7:0]      rdata_reg, rdata_next;
  logic            rvalid_reg, rvalid_next;
  logic [7:0]      uio_out_reg, uio_out_next;
  logic [7:0]      uio_oe_reg, uio_oe_next;

  logic [NREQ-1:0] owner_mask;
  logic [NREQ-1:0] others;
  logic            release_now;
  logic [IW-1:0]   after_owner;
  logic [IW-1:0]   idle_pick;
  logic [IW-1:0]   handoff_pick;

  // First set bit searching upward from start, wrapping; optional fixed priority for requester 0.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] start);
    logic [IW-1:0] win;
    int idx;
    win = start;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NREQ;
      if (r[idx]) win = IW'(idx);
    end
`ifdef UIO_ARB_PRIO0_EN
    if (r[0]) win = '0;
`endif
    return win;
  endfunction

  assign owner_mask   = NREQ'(1) << owner_reg;
  assign others       = req & ~owner_mask;
  assign after_owner  = (int'(owner_reg) == NREQ - 1) ? '0 : owner_reg + 1'b1;
  assign idle_pick    = rr_pick(req, rr_ptr_reg);
  assign handoff_pick = rr_pick(others, after_owner);
  assign release_now  = done[owner_reg] || !req[owner_reg] ||
                        ((hold_cnt_reg == HCW'(HOLD_MAX)) && (|others));

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    dir_next      = dir_reg;
    turn_cnt_next = turn_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    rr_ptr_next   = rr_ptr_reg;
    gnt_next      = gnt_reg;
    rdata_next    = rdata_reg;
    rvalid_next   = 1'b0;
    uio_out_next  = 8'h00;
    uio_oe_next   = 8'h00;
    case (state_reg)
      S_IDLE: begin
        gnt_next = '0;
        if (|req) begin
          owner_next    = idle_pick;
          dir_next      = dir[idle_pick];
          turn_cnt_next = '0;
          state_next    = S_TURN;
        end
      end
      S_TURN: begin
        gnt_next = '0;
        if (turn_cnt_reg == TCW'(TURN)) begin
          state_next    = S_OWN;
          gnt_next      = owner_mask;
          hold_cnt_next = HCW'(1);
        end else begin
          turn_cnt_next = turn_cnt_reg + 1'b1;
        end
      end
      S_OWN: begin
        if (release_now) begin
          gnt_next      = '0;
          hold_cnt_next = '0;
          rr_ptr_next   = after_owner;
          if (|others) begin
            // Hand over directly; the ex-owner is excluded so a timed-out owner cannot win back.
            owner_next    = handoff_pick;
            dir_next      = dir[handoff_pick];
            turn_cnt_next = '0;
            state_next    = S_TURN;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          if (dir_reg) begin
            uio_oe_next  = 8'hFF;
            uio_out_next = wdata[{owner_reg, 3'b000} +: 8];
          end else begin
            rdata_next  = uio_in;
            rvalid_next = 1'b1;
          end
          if (hold_cnt_reg != HCW'(HOLD_MAX)) hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      owner_reg    <= '0;
      dir_reg      <= 1'b0;
      turn_cnt_reg <= '0;
      hold_cnt_reg <= '0;
      rr_ptr_reg   <= '0;
      gnt_reg      <= '0;
      rdata_reg    <= 8'h00;
      rvalid_reg   <= 1'b0;
      uio_out_reg  <= 8'h00;
      uio_oe_reg   <= 8'h00;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      dir_reg      <= dir_next;
      turn_cnt_reg <= turn_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      rr_ptr_reg   <= rr_ptr_next;
      gnt_reg      <= gnt_next;
      rdata_reg    <= rdata_next;
      rvalid_reg   <= rvalid_next;
      uio_out_reg  <= uio_out_next;
      uio_oe_reg   <= uio_oe_next;
    end
  end

  assign gnt     = gnt_reg;
  assign rdata   = rdata_reg;
  assign rvalid  = rvalid_reg;
  assign busy    = (state_reg != S_IDLE);
  assign uio_out = uio_out_reg;
  assign uio_oe  = uio_oe_reg;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: directed scenarios plus random traffic, every cycle checked against a tenure-level model.
module tb_uio_bus_arbiter;
  localparam int NREQ     = 4;
  localparam int TURN     = 1;
  localparam int HOLD_MAX = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   dir = '0;
  logic [NREQ-1:0]   done = '0;
  logic [NREQ*8-1:0] wdata = '0;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        rdata;
  logic              rvalid;
  logic              busy;
  logic [7:0]        uio_in = 8'h00;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;

  uio_bus_arbiter #(.NREQ(NREQ), .TURN(TURN), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir), .done(done), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .busy(busy),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: owner -1 means idle; gap counts edges left before the grant appears.
  int              m_owner = -1;
  int              m_gap = 0;
  int              m_len = 0;
  int              m_rr = 0;
  bit              m_dir = 1'b0;
  logic [NREQ-1:0] e_gnt = '0;
  logic [7:0]      e_oe = 8'h00;
  logic [7:0]      e_out = 8'h00;
  logic [7:0]      e_rdata = 8'h00;
  logic            e_rvalid = 1'b0;

  function automatic int pick(input logic [NREQ-1:0] r, input int start);
`ifdef UIO_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++)
      if (r[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  task automatic model_edge();
    logic [NREQ-1:0] oth;
    bit rel;
    if (rst) begin
      m_owner = -1; m_gap = 0; m_len = 0; m_rr = 0;
      e_gnt = '0; e_oe = 8'h00; e_out = 8'h00; e_rvalid = 1'b0; e_rdata = 8'h00;
    end else if (m_owner < 0) begin
      e_gnt = '0; e_oe = 8'h00; e_out = 8'h00; e_rvalid = 1'b0;
      if (req != 0) begin
        m_owner = pick(req, m_rr);
        m_dir   = dir[m_owner];
        m_gap   = TURN + 1;
      end
    end else if (m_gap > 0) begin
      e_oe = 8'h00; e_out = 8'h00; e_rvalid = 1'b0;
      m_gap--;
      if (m_gap == 0) begin
        e_gnt = NREQ'(1) << m_owner;
        m_len = 1;
        $display("grant req=%0d dir=%0d t=%0t", m_owner, m_dir, $time);
      end
    end else begin
      oth = req;
      oth[m_owner] = 1'b0;
      rel = done[m_owner] || !req[m_owner] || (m_len == HOLD_MAX && oth != 0);
      if (rel) begin
        e_gnt = '0; e_oe = 8'h00; e_out = 8'h00; e_rvalid = 1'b0;
        m_rr = (m_owner + 1) % NREQ;
        if (oth != 0) begin
          m_owner = pick(oth, m_rr);
          m_dir   = dir[m_owner];
          m_gap   = TURN + 1;
        end else begin
          m_owner = -1;
        end
      end else begin
        if (m_dir) begin
          e_oe = 8'hFF; e_out = wdata[m_owner*8 +: 8]; e_rvalid = 1'b0;
        end else begin
          e_oe = 8'h00; e_out = 8'h00; e_rdata = uio_in; e_rvalid = 1'b1;
        end
        if (m_len < HOLD_MAX) m_len++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt", gnt, e_gnt);
    check("uio_oe", uio_oe, e_oe);
    check("uio_out", uio_out, e_out);
    check("rvalid", rvalid, e_rvalid);
    check("rdata", rdata, e_rdata);
    check("busy", busy, m_owner >= 0);
    check("gnt_onehot0", $onehot0(gnt), 1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_gnt(input logic [NREQ-1:0] want, output int n);
    n = 0;
    while (gnt !== want && n < 100) begin
      step();
      n++;
    end
    if (gnt !== want) check("wait_gnt", gnt, want);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; done = '0;
    steps(2);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    int order[$];
    int own_cycles;
    logic [NREQ-1:0] prio_exp;

    do_reset();
    check("reset_gnt", gnt, 0);
    check("reset_oe", uio_oe, 0);
    check("reset_busy", busy, 0);

    // Write tenure on requester 1
    req = 4'b0010; dir = 4'b0010; wdata[15:8] = 8'hA5;
    step();
    step();
    check("wr_gnt_early", gnt, 4'b0000);
    step();
    check("wr_gnt", gnt, 4'b0010);
    step();
    check("wr_oe", uio_oe, 8'hFF);
    check("wr_out", uio_out, 8'hA5);
    req = '0;
    steps(3);

    // Read tenure on requester 2; its release leaves rr_ptr at 3
    req = 4'b0100; dir = 4'b0000; uio_in = 8'h3C;
    steps(3);
    check("rd_gnt", gnt, 4'b0100);
    step();
    check("rd_oe", uio_oe, 8'h00);
    check("rd_rdata", rdata, 8'h3C);
    check("rd_rvalid", rvalid, 1);
    done = 4'b0100;
    step();
    done = '0; req = '0;
    steps(3);

    // Arbitration from rr_ptr=3
    req = 4'b1001;
    steps(TURN + 2);
`ifdef UIO_ARB_PRIO0_EN
    prio_exp = 4'b0001;
`else
    prio_exp = 4'b1000;
`endif
    check("prio_gnt", gnt, prio_exp);
    req = '0;
    steps(3);

    // Fairness: all request, owner pulses done 3 cycles into its tenure
    do_reset();
    req = 4'b1111; dir = 4'b1111;
    cnt = 0;
    for (int i = 0; i < 200 && order.size() < NREQ; i++) begin
      step();
      cnt = (gnt != 0) ? cnt + 1 : 0;
      if (cnt == 1)
        for (int b = 0; b < NREQ; b++) if (gnt[b]) order.push_back(b);
      done = (cnt == 3) ? gnt : '0;
    end
    done = '0;
    check("fair_count", order.size(), NREQ);
    for (int i = 0; i < order.size(); i++) check("fair_order", order[i], i);

    // Timeout: requester 0 owns, requester 1 contends
    do_reset();
    req = 4'b0001; dir = 4'b0001;
    wait_gnt(4'b0001, n);
    req = 4'b0011;
    own_cycles = 1;
    while (gnt === 4'b0001 && own_cycles < 100) begin
      step();
      if (gnt === 4'b0001) own_cycles++;
    end
    check("tmo_hold", own_cycles, HOLD_MAX);
    wait_gnt(4'b0010, n);
    check("tmo_handoff", n, TURN + 1);

    // Reset in the middle of a write tenure
    do_reset();
    req = 4'b1000; dir = 4'b1000; wdata[31:24] = 8'h5A;
    wait_gnt(4'b1000, n);
    step();
    check("mid_oe_pre", uio_oe, 8'hFF);
    rst = 1'b1;
    step();
    check("mid_gnt", gnt, 0);
    check("mid_oe", uio_oe, 0);
    check("mid_out", uio_out, 0);
    check("mid_busy", busy, 0);
    rst = 1'b0; req = '0;
    steps(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NREQ; b++) begin
        if ($urandom_range(7) == 0) req[b] = ~req[b];
        done[b] = ($urandom_range(15) == 0);
      end
      dir    = NREQ'($urandom);
      wdata  = {$urandom};
      uio_in = 8'($urandom);
      rst    = ($urandom_range(499) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
